// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter sharing one data channel through a 4:1 mux.
// The owner holds the channel for up to max_burst accepted beats, then rotates.

module mux4input #(
    parameter int width = 32
) (
    input  logic [1:0]       sel,
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] in2,
    input  logic [width-1:0] in3,
    output logic [width-1:0] out
);
    always_comb begin
        out = in0;
        case (sel)
            2'd0: out = in0;
            2'd1: out = in1;
            2'd2: out = in2;
            2'd3: out = in3;
            default: out = in0;
        endcase
    end
endmodule

// Handshake: a beat moves from requester i when grant[i] & req[i] & ready are all
// high in the same cycle; ack[i] reports that transfer, out_valid = req of the owner.
module rr_mux_arbiter #(
    parameter int width     = 32,
    parameter int max_burst = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [width-1:0] in0,
    input  logic [width-1:0] in1,
    input  logic [width-1:0] in2,
    input  logic [width-1:0] in3,
    input  logic             ready,
    output logic [width-1:0] out,
    output logic             out_valid,
    output logic [1:0]       sel,
    output logic [3:0]       grant,
    output logic [3:0]       ack,
    output logic             state_dbg
);
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] last_beat = 8'(max_burst - 1);

    state_t     state;
    logic [1:0] last;
    logic [7:0] beat_cnt;

    logic       owner_req;
    logic       beat_done;
    logic       capped;
    logic       release_now;
    logic [3:0] hand_req;
    logic       idle_any;
    logic       hand_any;
    logic [1:0] idle_pick;
    logic [1:0] hand_pick;

    // First set bit of r at or after index start, wrapping modulo 4.
    function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] r);
        logic [1:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (r[idx] && !found) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    always_comb begin
        owner_req   = req[sel];
        out_valid   = (state == GRANT) && owner_req;
        ack         = grant & req & {4{ready}};
        beat_done   = |ack;
        capped      = beat_done && (beat_cnt == last_beat);
        release_now = (state == GRANT) && (!owner_req || capped);
        // The releasing owner never competes for the direct hand-over; a capped
        // sole requester therefore goes through IDLE and is re-granted from there.
        hand_req    = req & ~grant;
        idle_any    = |req;
        hand_any    = |hand_req;
        idle_pick   = pick(last + 2'd1, req);
        hand_pick   = pick(sel + 2'd1, hand_req);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= 2'd0;
            grant    <= 4'b0000;
            beat_cnt <= 8'd0;
            last     <= 2'd3;
        end else begin
            case (state)
                IDLE: begin
                    if (idle_any) begin
                        state    <= GRANT;
                        sel      <= idle_pick;
                        grant    <= onehot(idle_pick);
                        beat_cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        last     <= sel;
                        beat_cnt <= 8'd0;
                        if (hand_any) begin
                            sel   <= hand_pick;
                            grant <= onehot(hand_pick);
                        end else begin
                            state <= IDLE;
                            sel   <= 2'd0;
                            grant <= 4'b0000;
                        end
                    end else if (beat_done) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= 2'd0;
                    grant <= 4'b0000;
                end
            endcase
        end
    end

    assign state_dbg = state;

    mux4input #(.width(width)) u_mux (
        .sel (sel),
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .out (out)
    );
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Four-requester round-robin arbiter that shares one `width`-bit downstream channel.
- Holds a registered owner index, which drives the select of an internal mux4input instance.
- Generates per-requester accept strobes under a valid/ready handshake.
- Caps each grant at `max_burst` beats so that no requester can starve the others.

Parameters:
- width, 32, data width of each requester input and of the output.
- max_burst, 4, maximum beats accepted per grant; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request from requester i; held high while data is pending.
- in0, in1, in2, in3  input  width  requester data; must be stable while req[i]=1 and ack[i]=0.
- ready  input  1  downstream can accept a beat this cycle.
- out  output  width  data of the current owner; always equals the in[sel] mux output.
- out_valid  output  1  out carries a valid beat.
- sel  output  2  current owner index; registered.
- grant  output  4  one-hot owner indicator; all zeros in IDLE.
- ack  output  4  beat accepted from requester i this cycle (grant[i] & req[i] & ready).

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, sel=0, grant=0000, out_valid=0, ack=0000, beat_cnt=0, last=3 (so the first search starts at requester 0).
- Reset asserted mid-burst: the next edge forces all reset values; the in-flight burst is abandoned with no ack.
- State machine has two states, IDLE and GRANT.
- Winner selection: scan the requesters starting at (last+1) mod 4 and pick the first with req=1.
- IDLE:
  - If any req=1, load sel=winner, set grant=onehot(winner), clear beat_cnt, go to GRANT.
  - Req-to-out_valid latency is 1 cycle.
  - If no req=1, stay in IDLE.
- GRANT, outputs:
  - out_valid = req[sel] (combinational from the registered sel).
  - ack[sel] = req[sel] & ready; every other ack bit is 0.
- GRANT, counting: on each ack, beat_cnt increments by 1 (8-bit counter).
- GRANT, release condition: req[sel]=0, or (ack and beat_cnt = max_burst-1).
- On release:
  - last <= sel.
  - If another req is pending this cycle, excluding the releasing requester when it was burst-capped, load the new winner directly (stay in GRANT, no idle cycle) and clear beat_cnt.
  - Otherwise go to IDLE with grant=0000.
- Burst-capped requester: if it keeps req=1, it is re-granted only after the other pending requesters have each been served. If it is the only requester, it is re-granted on the next cycle.
- The default max_burst=4 gives at most 4 consecutive acks per grant.
- ready=0 stalls the transfer: no ack, beat_cnt holds, grant holds, out_valid stays high.
- Requester drops req while ready=1: treated as release; no ack that cycle.
- A new req arriving mid-burst does not preempt the owner.
- out is driven by the internal mux from sel in every state. In IDLE it shows in0, and it is don't-care whenever out_valid=0.
- max_burst=1: exactly one beat per grant; strict rotation whenever two or more requesters are active.

Test Plan:
- Reset then single requester: req=0001, ready=1, in0=0xA5A5A5A5.
  - out_valid rises 1 cycle after req.
  - sel=0, out=0xA5A5A5A5.
  - ack[0] pulses 4 times, then a 1-cycle grant gap, then re-granted (sole requester).
- All four request continuously: req=1111, ready=1, max_burst=4.
  - Grant order 0,1,2,3,0 with 4 acks each.
  - Owner changes back-to-back with no IDLE cycle.
- Backpressure: owner 2, ready toggles 1,0,0,1,1,1.
  - ack[2] only on ready=1 cycles; beat_cnt holds during stalls.
  - Release after the 4th ack; out_valid stays 1 throughout.
- Early drop: req=0011; requester 0 drops req after 2 acks.
  - Grant moves to requester 1 on the next edge; requester 1 receives up to 4 acks.
- Reset mid-burst: reset=1 for one cycle during requester 3's 2nd beat.
  - Next cycle: grant=0000, out_valid=0, sel=0.
  - Arbitration restarts at requester 0 if req=1111.
- Late arrival: req=0100 granted; req[1] asserts during the burst.
  - No preemption; requester 1 is granted only after requester 2 releases.
